vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster controller.
- Generates programmable H/V timing, sync polarity and pixel-RAM addressing.
- Adds configurable RAM read latency, a 2x pixel-doubling mode, a count enable and frame/line markers.
- Sits between the pixel framebuffer RAM and the VGA DAC/connector pins. Replaces the fixed 640x480, 4-bit-per-channel controller.

Parameters:
- H_SYNC, 96, horizontal sync pulse width (pixels)
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- HS_POL, 0, hs active level (0 = active-low)
- VS_POL, 0, vs active level
- CW, 4, bits per colour channel
- COL_W, 10, col_addr width
- ROW_W, 9, row_addr width
- RD_LAT, 1, pixel-RAM read latency in cycles (1..4)

Ports:
- vga_clk  in  1  pixel clock (25 MHz at defaults)
- rst  in  1  asynchronous, active-high reset
- en  in  1  count enable; 0 freezes the raster
- scale2  in  1  1 = 2x pixel doubling (320x240 addressing at defaults)
- d_in  in  3*CW  pixel data, {b,g,r}
- row_addr  out  ROW_W  pixel RAM row address
- col_addr  out  COL_W  pixel RAM column address
- rdn  out  1  RAM read strobe, active-low
- r, g, b  out  CW each  colour outputs
- hs, vs  out  1 each  sync outputs
- frame_start  out  1  one-cycle pulse, aligned with the first active pixel on r/g/b
- line_start  out  1  one-cycle pulse, aligned with the first active pixel of each active line on r/g/b

Behaviour:
- Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise.
- h_cnt runs 0..H_TOTAL-1 and wraps. v_cnt advances when h_cnt wraps, and wraps at V_TOTAL-1.
- Phase order per axis: sync, back porch, active, front porch. Sync is asserted while cnt < SYNC.
- Active region: h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and v_cnt in the V equivalent.
- Stage 1 (one cycle after the counter value):
  - col = h_cnt - (H_SYNC+H_BP); row = v_cnt - (V_SYNC+V_BP).
  - Truncated to COL_W/ROW_W; right-shifted by 1 when the mode bit is set.
  - rdn = ~active.
- d_in is valid RD_LAT cycles after the stage-1 address.
- r/g/b are registered from d_in using rdn delayed by RD_LAT. Output is 0 when the delayed rdn is 1.
- hs, vs, frame_start and line_start pass through a delay line so all of them are aligned with r/g/b.
- Total latency counter -> pins = RD_LAT+2 cycles.
- Mode bit: scale2 is sampled only at h_cnt==0, v_cnt==0 with en=1. A mid-frame change takes effect at the next frame.
- en=0:
  - Counters hold.
  - Stage-1 rdn is forced to 1.
  - hs/vs hold their current value.
  - The pipeline keeps shifting, so in-flight pixels drain and then r/g/b read 0.
- Reset (asynchronous, active-high), all outputs:
  - counters = 0, row_addr = col_addr = 0, rdn = 1, r/g/b = 0
  - hs = ~HS_POL, vs = ~VS_POL, frame_start = line_start = 0, mode bit = 0
  - Counting restarts from 0 on the first edge after release.
- Boundaries:
  - Last pixel of the frame wraps both counters in the same cycle.
  - The first active pixel of a frame asserts frame_start and line_start together.
- Elaboration checks: COL_W >= clog2(H_ACTIVE) and ROW_W >= clog2(V_ACTIVE). A violation is fatal.

Optional Feature:
- Macro: VGA_TIMING_BORDER_EN.
- When defined:
  - Adds input border_rgb [3*CW-1:0].
  - Pixels on the outermost 1-pixel rim of the active area show border_rgb instead of d_in.
  - rdn stays 1 on rim pixels, so the RAM is not read.
- When undefined: no port is added, and the active area shows d_in everywhere.

Decomposition:
- Package vga_pkg:
  - default 640x480@60 timing constants
  - a total-length function
  - the RGB packing offsets (r = [CW-1:0], g = [2CW-1:CW], b = [3CW-1:2CW])
- Sub-module vga_axis_counter, instantiated twice (H and V).
  - Parameters: SYNC, BP, ACTIVE, FP.
  - Inputs: tick.
  - Outputs: cnt, wrap, sync, active, first_active.
  - Independently testable.

Test Plan:
- Reset release, defaults, en=1:
  - hs low for 96 cycles every 800; vs low for 1600 cycles every 420000.
  - First hs falling edge appears RD_LAT+2 = 3 cycles after release.
- Counter at h=144, v=35:
  - Next cycle: col_addr=0, row_addr=0, rdn=0.
  - RAM model returns 12'hABC after 1 cycle, giving r=C, g=B, b=A plus frame_start=1 at cycle +3.
- d_in held at 12'hFFF:
  - r/g/b = 0 for all h<144 or h>783 or v<35 or v>514.
  - Exactly 640x480 nonzero pixels per frame.
- scale2=1 raised mid-frame: addresses unchanged until the next frame. Then col_addr steps 0,0,1,1..319,319 and each row_addr repeats on 2 lines, 0..239.
- rst pulse at h=400 mid-line: outputs take reset values within the same cycle without a clock edge; the raster restarts at 0.
- en=0 for 10 cycles at h=500: counters hold, rdn=1, that line lasts 810 cycles, and the next line is 800 cycles.
- Alternate build RD_LAT=3, HS_POL=1: hs is high during the pulse, and latency is 5 cycles.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing defaults, control bundle and helpers for the VGA raster.
// Provides 640x480@60 constants, axis_total() and RGB slice indices.
package vga_pkg;

   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;

   // Channel slot within a packed {b,g,r} word, in units of CW.
   localparam int R_IDX = 0;
   localparam int G_IDX = 1;
   localparam int B_IDX = 2;

   // Sync/marker/read-strobe bundle carried down the delay line.
   typedef struct packed {
      logic hs;
      logic vs;
      logic fs;
      logic ls;
      logic rdn;
   } vga_ctl_t;

   function automatic int axis_total(
      input int sync_w,
      input int bp_w,
      input int act_w,
      input int fp_w
   );
      return sync_w + bp_w + act_w + fp_w;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counter with sync / back porch / active / front porch.
// Ports: vga_clk, rst, tick in; cnt, wrap, sync, active, first_active out.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int SYNC   = DEF_H_SYNC,
   parameter int BP     = DEF_H_BP,
   parameter int ACTIVE = DEF_H_ACTIVE,
   parameter int FP     = DEF_H_FP,
   parameter int CNT_W  = $clog2(axis_total(SYNC, BP, ACTIVE, FP))
)(
   input  logic             vga_clk,
   input  logic             rst,
   input  logic             tick,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap,
   output logic             sync,
   output logic             active,
   output logic             first_active
);

   localparam int TOTAL = axis_total(SYNC, BP, ACTIVE, FP);
   localparam int A_LO  = SYNC + BP;
   localparam int A_HI  = SYNC + BP + ACTIVE - 1;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC);
   localparam logic [CNT_W-1:0] ACT_LO = CNT_W'(A_LO);
   localparam logic [CNT_W-1:0] ACT_HI = CNT_W'(A_HI);

   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= wrap ? '0 : cnt + 1'b1;
      end
   end

   assign wrap         = (cnt == LAST);
   assign sync         = (cnt < SYNC_END);
   assign active       = (cnt >= ACT_LO) && (cnt <= ACT_HI);
   assign first_active = (cnt == ACT_LO);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster: H/V timing, pixel-RAM addressing, RD_LAT-aligned RGB out.
// In: vga_clk rst en scale2 d_in; out: row/col_addr rdn r g b hs vs
// frame_start line_start. VGA_TIMING_BORDER_EN adds border_rgb rim.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = 4,
   parameter int COL_W    = 10,
   parameter int ROW_W    = 9,
   parameter int RD_LAT   = 1
)(
   input  logic              vga_clk,
   input  logic              rst,
   input  logic              en,
   input  logic              scale2,
   input  logic [3*CW-1:0]   d_in,
`ifdef VGA_TIMING_BORDER_EN
   input  logic [3*CW-1:0]   border_rgb,
`endif
   output logic [ROW_W-1:0]  row_addr,
   output logic [COL_W-1:0]  col_addr,
   output logic              rdn,
   output logic [CW-1:0]     r,
   output logic [CW-1:0]     g,
   output logic [CW-1:0]     b,
   output logic              hs,
   output logic              vs,
   output logic              frame_start,
   output logic              line_start
);

   localparam int H_TOTAL =
      axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
   localparam int V_TOTAL =
      axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam int H_OFF = H_SYNC + H_BP;
   localparam int V_OFF = V_SYNC + V_BP;

   localparam vga_ctl_t CTL_RST = '{
      hs:  ~HS_POL,
      vs:  ~VS_POL,
      fs:  1'b0,
      ls:  1'b0,
      rdn: 1'b1
   };

   if (COL_W < $clog2(H_ACTIVE)) begin : g_bad_col_w
      $fatal(1, "COL_W too narrow for H_ACTIVE");
   end
   if (ROW_W < $clog2(V_ACTIVE)) begin : g_bad_row_w
      $fatal(1, "ROW_W too narrow for V_ACTIVE");
   end
   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $fatal(1, "RD_LAT must be 1..4");
   end

   logic [HW-1:0] h_cnt;
   logic          h_wrap;
   logic          h_sync;
   logic          h_act;
   logic          h_first;
   logic [VW-1:0] v_cnt;
   logic          v_wrap;
   logic          v_sync;
   logic          v_act;
   logic          v_first;

   vga_axis_counter #(
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .CNT_W  (HW)
   ) u_h_cnt (
      .vga_clk      (vga_clk),
      .rst          (rst),
      .tick         (en),
      .cnt          (h_cnt),
      .wrap         (h_wrap),
      .sync         (h_sync),
      .active       (h_act),
      .first_active (h_first)
   );

   vga_axis_counter #(
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .CNT_W  (VW)
   ) u_v_cnt (
      .vga_clk      (vga_clk),
      .rst          (rst),
      .tick         (en & h_wrap),
      .cnt          (v_cnt),
      .wrap         (v_wrap),
      .sync         (v_sync),
      .active       (v_act),
      .first_active (v_first)
   );

   // origin tracks h_cnt==0 && v_cnt==0 without wide compares:
   // the counters only reach 0/0 from a double wrap or from reset.
   logic origin;
   logic mode;

   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         origin <= 1'b1;
         mode   <= 1'b0;
      end else if (en) begin
         if (origin) begin
            mode <= scale2;
         end
         origin <= h_wrap & v_wrap;
      end
   end

   logic             pix_act;
   logic             rd_act;
   logic [COL_W-1:0] col_rel;
   logic [ROW_W-1:0] row_rel;
   logic [COL_W-1:0] col_nxt;
   logic [ROW_W-1:0] row_nxt;
   vga_ctl_t         s1_nxt;

   assign pix_act = h_act & v_act & en;

   // Modular subtraction in the address width is the truncation.
   assign col_rel = COL_W'(h_cnt) - COL_W'(H_OFF);
   assign row_rel = ROW_W'(v_cnt) - ROW_W'(V_OFF);
   assign col_nxt = mode ? (col_rel >> 1) : col_rel;
   assign row_nxt = mode ? (row_rel >> 1) : row_rel;

`ifdef VGA_TIMING_BORDER_EN
   localparam logic [HW-1:0] H_LAST = HW'(H_OFF + H_ACTIVE - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_OFF + V_ACTIVE - 1);

   logic rim;

   assign rim = pix_act & (h_first | v_first |
                           (h_cnt == H_LAST) |
                           (v_cnt == V_LAST));
   assign rd_act = pix_act & ~rim;
`else
   assign rd_act = pix_act;
`endif

   always_comb begin
      s1_nxt     = CTL_RST;
      s1_nxt.hs  = h_sync ? HS_POL : ~HS_POL;
      s1_nxt.vs  = v_sync ? VS_POL : ~VS_POL;
      s1_nxt.fs  = pix_act & h_first & v_first;
      s1_nxt.ls  = pix_act & h_first;
      s1_nxt.rdn = ~rd_act;
   end

   // Stage 1 drives the RAM; pipe[] waits out the read latency.
   vga_ctl_t s1;
   vga_ctl_t pipe [RD_LAT];
   vga_ctl_t tail;

   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         s1       <= CTL_RST;
         col_addr <= '0;
         row_addr <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pipe[i] <= CTL_RST;
         end
      end else begin
         s1       <= s1_nxt;
         col_addr <= col_nxt;
         row_addr <= row_nxt;
         pipe[0]  <= s1;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign rdn  = s1.rdn;
   assign tail = pipe[RD_LAT-1];

   logic [3*CW-1:0] pix;

`ifdef VGA_TIMING_BORDER_EN
   logic s1_brd;
   logic brd_pipe [RD_LAT];

   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         s1_brd <= 1'b0;
         for (int i = 0; i < RD_LAT; i++) begin
            brd_pipe[i] <= 1'b0;
         end
      end else begin
         s1_brd      <= rim;
         brd_pipe[0] <= s1_brd;
         for (int i = 1; i < RD_LAT; i++) begin
            brd_pipe[i] <= brd_pipe[i-1];
         end
      end
   end

   always_comb begin
      pix = '0;
      if (!tail.rdn) begin
         pix = d_in;
      end
      if (brd_pipe[RD_LAT-1]) begin
         pix = border_rgb;
      end
   end
`else
   always_comb begin
      pix = '0;
      if (!tail.rdn) begin
         pix = d_in;
      end
   end
`endif

   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         r           <= '0;
         g           <= '0;
         b           <= '0;
         hs          <= ~HS_POL;
         vs          <= ~VS_POL;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
      end else begin
         r           <= pix[R_IDX*CW +: CW];
         g           <= pix[G_IDX*CW +: CW];
         b           <= pix[B_IDX*CW +: CW];
         hs          <= tail.hs;
         vs          <= tail.vs;
         frame_start <= tail.fs;
         line_start  <= tail.ls;
      end
   end

endmodule
